// File: rtl/calculator_pkg.sv
// calculator_pkg: shared widths and types for the calculator datapath.
package calculator_pkg;
    localparam int DATA_W     = 32;
    localparam int CHUNK_W    = 8;
    localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
    typedef enum logic [1:0] {IDLE, CALC, DONE} sub_state_e;
endpackage

// File: rtl/sub_slice.sv
// sub_slice: combinational W-bit ripple subtractor built from full adders (a + ~b + ~bin).
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module sub_slice
    import calculator_pkg::*;
#(
    parameter int W = CHUNK_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);
    logic [W:0] c;
    // carry into the adder chain is the complement of the incoming borrow
    assign c[0] = ~bin;
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a_i(a[i]),
            .b_i(~b[i]),
            .c_i(c[i]),
            .s_o(d[i]),
            .c_o(c[i+1])
        );
    end
    assign bout = ~c[W];
endmodule

// File: rtl/sub32_seq.sv
// sub32_seq: multi-cycle subtractor, one CHUNK_W slice per cycle with a registered borrow.
module sub32_seq
    import calculator_pkg::*;
#(
    parameter int CHUNK_W = calculator_pkg::CHUNK_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] diff_o,
    output logic              borrow_o,
    output logic              ovf_o
);
    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int IDX_W  = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    if (DATA_W % CHUNK_W != 0) begin : g_chunk_chk
        $error("CHUNK_W must divide DATA_W");
    end

    sub_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              borrow_q, ovf_q, ovf_d;
    logic [DATA_W-1:0] a_q, b_q, diff_q;
    logic [CHUNK_W-1:0] s_a, s_b, s_d;
    logic              s_bout;

    assign s_a = a_q[idx_q*CHUNK_W +: CHUNK_W];
    assign s_b = b_q[idx_q*CHUNK_W +: CHUNK_W];

    sub_slice #(.W(CHUNK_W)) u_slice (
        .a(s_a),
        .b(s_b),
        .bin(borrow_q),
        .d(s_d),
        .bout(s_bout)
    );

    // on the last slice, s_d's top bit is the result sign
    assign ovf_d = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (s_d[CHUNK_W-1] != a_q[DATA_W-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            diff_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (valid_i) begin
                    a_q      <= a_i;
                    b_q      <= b_i;
                    diff_q   <= '0;
                    idx_q    <= '0;
                    borrow_q <= 1'b0;
                    ovf_q    <= 1'b0;
                    state_q  <= CALC;
                end
                CALC: begin
                    diff_q[idx_q*CHUNK_W +: CHUNK_W] <= s_d;
                    borrow_q <= s_bout;
                    if (idx_q == LAST) begin
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: if (ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE) && !rst_i;
    assign valid_o  = (state_q == DONE) && !rst_i;
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_sub32_seq.sv
// tb_sub32_seq: directed vectors with a scoreboard queue drained by an output monitor.
module tb_sub32_seq;
    typedef struct {
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
    } exp_t;

    logic        clk = 0;
    logic        rst_i = 1, valid_i = 0, ready_i = 1;
    logic [31:0] a_i = 0, b_i = 0;
    logic        ready_o, valid_o, borrow_o, ovf_o;
    logic [31:0] diff_o;
    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;

    sub32_seq dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
        .diff_o(diff_o), .borrow_o(borrow_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", diff_o, e.diff);
                chk("borrow", {31'd0, borrow_o}, {31'd0, e.borrow});
                chk("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                         input logic bo, input logic ov, input bit push);
        int t = 0;
        while (!ready_o && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'd1, 32'd0);
        if (push) sb.push_back('{d, bo, ov});
        a_i = a; b_i = b; valid_i = 1;
        @(posedge clk); #1;
        valid_i = 0;
    endtask

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_diff", diff_o, 32'd0);
        rst_i = 0;
        #1;
        chk("post_rst_ready", {31'd0, ready_o}, 32'd1);

        issue(32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1);
        cnt = 0;
        while (!valid_o && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 32'd4);

        issue(32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        issue(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
        issue(32'h0100_0000, 32'd1, 32'h00FF_FFFF, 1'b0, 1'b0, 1);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1);

        // backpressure with a stray request held during CALC and DONE
        while (!ready_o) begin
            @(posedge clk); #1;
        end
        ready_i = 0;
        issue(32'h1234_5678, 32'h1111_1111, 32'h0123_4567, 1'b0, 1'b0, 1);
        a_i = 32'hFFFF_FFFF; b_i = 32'd0; valid_i = 1;
        cnt = 0;
        while (!valid_o && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, valid_o}, 32'd1);
            chk("bp_ready", {31'd0, ready_o}, 32'd0);
            chk("bp_diff", diff_o, 32'h0123_4567);
            chk("bp_flags", {30'd0, borrow_o, ovf_o}, 32'd0);
        end
        valid_i = 0;
        ready_i = 1;
        @(posedge clk); #1;

        // reset while CALC is on slice 2 discards the operation
        issue(32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1 rst_i = 1;
        #1 chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
        @(posedge clk);
        #1 rst_i = 0;
        #1;
        chk("after_rst_ready", {31'd0, ready_o}, 32'd1);
        chk("after_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("after_rst_diff", diff_o, 32'd0);
        chk("after_rst_flags", {30'd0, borrow_o, ovf_o}, 32'd0);
        issue(32'd5, 32'd9, 32'hFFFF_FFFC, 1'b1, 1'b0, 1);

        cnt = 0;
        while (sb.size() != 0 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
